mem_io_responder: RTL and testbench
===================================

Name: mem_io_responder

Overview:
- Responder end of the byte-serial memory bus driven by the memory controller.
- Services one byte access per cycle: RAM reads with 1-cycle registered latency, RAM writes, and two memory-mapped IO ports at 0x30000 (byte data) and 0x30004 (status/halt).
- Owns the TX byte FIFO behind 0x30000 and generates io_buffer_full back-pressure to the controller.
- Sits between the memory controller and the on-chip RAM / UART host link.

Parameters:
- ADDR_WIDTH, 17, RAM byte-address bits; RAM holds 2^ADDR_WIDTH bytes.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2 and at least 4.
- FULL_HEADROOM, 2, io_buffer_full asserts when FIFO count >= FIFO_DEPTH - FULL_HEADROOM.
- TX_INTERVAL, 4, minimum cycles between consecutive TX pops; must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; 0 freezes all state
- mem_a  in  32  byte address from controller
- mem_wr  in  1  1 = write mem_din at mem_a, 0 = read
- mem_din  in  8  write byte
- mem_dout  out  8  read byte for the address presented in the previous cycle
- io_buffer_full  out  1  TX FIFO near-full back-pressure
- rx_valid  in  1  host offers an input byte
- rx_data  in  8  input byte
- rx_ready  out  1  RX holding register empty
- tx_valid  out  1  1-cycle pulse, tx_data valid
- tx_data  out  8  output byte
- tx_ready  in  1  host can accept a TX byte
- halt  out  1  sticky; program finished

Behaviour:
- Decode: is_io = (mem_a[17:16] == 2'b11). RAM index = mem_a[ADDR_WIDTH-1:0].
- Reset (rst=1 at posedge) drives:
  - mem_dout=0, io_buffer_full=0, tx_valid=0, tx_data=0, halt=0, rx_ready=1.
  - FIFO empty (count=0); RX holding register empty; interval counter=0.
  - RAM contents are not reset.
  - Reset overrides rdy. Reset during a FIFO drain discards the queued bytes.
- rdy=0: no RAM write, no FIFO push/pop, no RX capture, and counters hold. mem_dout holds. tx_valid is forced to 0.
- RAM write (rdy, mem_wr, !is_io): ram[idx] <= mem_din at the posedge. mem_dout is unchanged.
- RAM read (rdy, !mem_wr, !is_io): mem_dout <= ram[idx]. Data is visible the cycle after the address. Back-to-back reads at consecutive addresses stream one byte per cycle.
- IO write at 0x30000: push mem_din into the TX FIFO. If the FIFO is full, the byte is dropped and FIFO state is unchanged.
- IO write at 0x30004: halt <= 1. halt stays set until rst.
- IO read at 0x30000:
  - mem_dout <= RX holding byte, and the holding register is cleared.
  - If the register is empty, mem_dout <= 0.
- IO read at 0x30004: mem_dout <= {6'b0, fifo_full, rx_held}.
- Other IO addresses (e.g. 0x30001-0x30003): reads return 0; writes are ignored. No side effects.
- RX capture: when rx_valid && rx_ready, the byte is latched. rx_ready = !rx_held, registered.
  - A 0x30000 read and a new capture in the same cycle: the read returns the old byte and the new byte is held.
- TX drain:
  - The interval counter counts up to TX_INTERVAL-1, then saturates.
  - A pop happens when counter saturated && count>0 && tx_ready. The pop sets tx_data <= head, pulses tx_valid for 1 cycle, and resets the counter to 0.
- Push and pop in the same cycle: count unchanged, ordering preserved (FIFO semantics).
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.
- io_buffer_full is registered from the next-state count: it reflects (count_next >= FIFO_DEPTH-FULL_HEADROOM). The headroom absorbs bytes the controller issues in the cycle before it observes the flag.

Decomposition:
- Shared package/defines:
  - IO_DATA_ADDR = 32'h30000, IO_STAT_ADDR = 32'h30004.
  - The IO decode field position [17:16].
  - Status bit indices STAT_RX_HELD=0, STAT_TX_FULL=1.
- Sub-module: byte_fifo, a parameterised sync FIFO with push, pop, head, count, full and empty. The RAM array and the IO decode stay in the top module.

Test Plan:
- RAM write then read: write 0xA5 to 0x00010, then read 0x00010 -> mem_dout=0xA5 exactly one cycle after the read address. Write 0x11/0x22/0x33/0x44 to 0x100-0x103 and read them back-to-back -> bytes stream 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
- TX flow, FIFO_DEPTH=8, TX_INTERVAL=4, tx_ready=1: write 0x48 then 0x69 to 0x30000 -> tx_valid pulses with tx_data 0x48 and then 0x69, pulses at least 4 cycles apart.
- Back-pressure, tx_ready=0: push 6 bytes -> io_buffer_full=1 the cycle after the 6th push. Push 3 more -> the 9th is dropped. Raise tx_ready -> exactly 8 bytes drain in order; io_buffer_full falls once count<6.
- RX/status: drive rx_valid with 0x7F -> rx_ready falls. Read 0x30004 -> 0x01. Read 0x30000 -> 0x7F and rx_ready returns to 1. Read 0x30000 again -> 0x00.
- Halt/rdy: with rdy=0, write to 0x30004 -> halt stays 0. With rdy=1, write to 0x30004 -> halt=1 next cycle and stays set. Assert rst mid-TX-drain -> all outputs at reset values and the FIFO is empty.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// Shared constants, access classification and address decode for the
// memory/IO responder.
package mem_io_responder_pkg;

  localparam logic [31:0] IO_DATA_ADDR = 32'h0003_0000;
  localparam logic [31:0] IO_STAT_ADDR = 32'h0003_0004;

  localparam int         IO_SEL_HI  = 17;
  localparam int         IO_SEL_LO  = 16;
  localparam logic [1:0] IO_SEL_VAL = 2'b11;

  localparam int STAT_RX_HELD = 0;
  localparam int STAT_TX_FULL = 1;

  typedef enum logic [2:0] {
    ACC_RAM_RD  = 3'd0,
    ACC_RAM_WR  = 3'd1,
    ACC_DATA_RD = 3'd2,
    ACC_DATA_WR = 3'd3,
    ACC_STAT_RD = 3'd4,
    ACC_STAT_WR = 3'd5,
    ACC_NONE_RD = 3'd6,
    ACC_NONE_WR = 3'd7
  } access_e;

  function automatic access_e decode_access(input logic [31:0] addr, input logic wr);
    access_e acc;
    if (addr[IO_SEL_HI:IO_SEL_LO] != IO_SEL_VAL) begin
      acc = wr ? ACC_RAM_WR : ACC_RAM_RD;
    end else if (addr == IO_DATA_ADDR) begin
      acc = wr ? ACC_DATA_WR : ACC_DATA_RD;
    end else if (addr == IO_STAT_ADDR) begin
      acc = wr ? ACC_STAT_WR : ACC_STAT_RD;
    end else begin
      acc = wr ? ACC_NONE_WR : ACC_NONE_RD;
    end
    return acc;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-serial memory bus plus host RX/TX link seen by the responder.
interface mem_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        io_buffer_full;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        halt;

  modport master (
    output mem_a, mem_wr, mem_din, rx_valid, rx_data, tx_ready,
    input  mem_dout, io_buffer_full, rx_ready, tx_valid, tx_data, halt
  );

  modport slave (
    input  mem_a, mem_wr, mem_din, rx_valid, rx_data, tx_ready,
    output mem_dout, io_buffer_full, rx_ready, tx_valid, tx_data, halt
  );
endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous byte FIFO; pushes into a full FIFO are dropped and pops from
// an empty one are ignored. en=0 freezes all state.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count_next,
  output logic                   full,
  output logic                   empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify push/pop and compute the next occupancy.
  always_comb begin
    push_ok_s    = en && push && (count_r != CNT_FULL);
    pop_ok_s     = en && pop && (count_r != '0);
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_next_s;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

  assign head       = mem_r[rd_ptr_r];
  assign count_next = count_next_s;
  assign full       = (count_r == CNT_FULL);
  assign empty      = (count_r == '0);

endmodule

// File: rtl/mem_io_responder.sv
// Responder for the byte-serial memory bus: on-chip RAM, RX holding byte,
// paced TX FIFO with near-full back-pressure, and a sticky halt flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int ADDR_WIDTH    = 17,
  parameter int FIFO_DEPTH    = 8,
  parameter int FULL_HEADROOM = 2,
  parameter int TX_INTERVAL   = 4
) (
  input logic               clk,
  input logic               rst,
  input logic               rdy,
  mem_io_responder_if.slave bus
);

  localparam int            CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int            IW          = $clog2(TX_INTERVAL + 1);
  localparam logic [CW-1:0] FULL_THRESH = CW'(FIFO_DEPTH - FULL_HEADROOM);
  localparam logic [IW-1:0] IVL_MAX     = IW'(TX_INTERVAL - 1);
  localparam logic [IW-1:0] IVL_ONE     = IW'(1);

  logic [7:0]            ram_r [1 << ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx_s;
  access_e               acc_s;

  logic [7:0]    mem_dout_r;
  logic          rx_held_r;
  logic [7:0]    rx_byte_r;
  logic          rx_ready_r;
  logic          halt_r;
  logic          tx_valid_r;
  logic [7:0]    tx_data_r;
  logic [IW-1:0] ivl_r;
  logic          io_full_r;

  logic          push_s;
  logic          pop_fire_s;
  logic          capture_s;
  logic          rx_clear_s;
  logic          rx_held_next_s;
  logic [7:0]    rx_byte_next_s;
  logic          dout_load_s;
  logic [7:0]    rd_data_s;
  logic [7:0]    status_s;
  logic [7:0]    fifo_head_s;
  logic [CW-1:0] fifo_count_next_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;

  assign idx_s = bus.mem_a[ADDR_WIDTH-1:0];
  assign acc_s = decode_access(bus.mem_a, bus.mem_wr);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .en         (rdy),
    .push       (push_s),
    .pop        (pop_fire_s),
    .din        (bus.mem_din),
    .head       (fifo_head_s),
    .count_next (fifo_count_next_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s)
  );

  // Access qualification, RX next state and read-data selection.
  always_comb begin
    push_s     = rdy && (acc_s == ACC_DATA_WR);
    pop_fire_s = rdy && (ivl_r == IVL_MAX) && !fifo_empty_s && bus.tx_ready;
    capture_s  = rdy && bus.rx_valid && rx_ready_r;
    rx_clear_s = rdy && (acc_s == ACC_DATA_RD);

    status_s               = 8'h00;
    status_s[STAT_RX_HELD] = rx_held_r;
    status_s[STAT_TX_FULL] = fifo_full_s;

    // A capture can only occur while the register is empty, so it always wins.
    if (capture_s) begin
      rx_held_next_s = 1'b1;
      rx_byte_next_s = bus.rx_data;
    end else if (rx_clear_s) begin
      rx_held_next_s = 1'b0;
      rx_byte_next_s = rx_byte_r;
    end else begin
      rx_held_next_s = rx_held_r;
      rx_byte_next_s = rx_byte_r;
    end

    dout_load_s = 1'b1;
    rd_data_s   = 8'h00;
    case (acc_s)
      ACC_RAM_RD:  rd_data_s = ram_r[idx_s];
      ACC_DATA_RD: rd_data_s = rx_held_r ? rx_byte_r : 8'h00;
      ACC_STAT_RD: rd_data_s = status_s;
      ACC_NONE_RD: rd_data_s = 8'h00;
      default:     dout_load_s = 1'b0;
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && rdy && (acc_s == ACC_RAM_WR)) ram_r[idx_s] <= bus.mem_din;
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_dout_r <= 8'h00;
      rx_held_r  <= 1'b0;
      rx_byte_r  <= 8'h00;
      rx_ready_r <= 1'b1;
      halt_r     <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      ivl_r      <= '0;
      io_full_r  <= 1'b0;
    end else begin
      rx_held_r  <= rx_held_next_s;
      rx_byte_r  <= rx_byte_next_s;
      rx_ready_r <= !rx_held_next_s;
      io_full_r  <= (fifo_count_next_s >= FULL_THRESH);
      if (rdy) begin
        if (dout_load_s) mem_dout_r <= rd_data_s;
        if (acc_s == ACC_STAT_WR) halt_r <= 1'b1;
        tx_valid_r <= pop_fire_s;
        if (pop_fire_s) begin
          tx_data_r <= fifo_head_s;
          ivl_r     <= '0;
        end else if (ivl_r != IVL_MAX) begin
          ivl_r <= ivl_r + IVL_ONE;
        end
      end else begin
        tx_valid_r <= 1'b0;
      end
    end
  end

  assign bus.mem_dout       = mem_dout_r;
  assign bus.io_buffer_full = io_full_r;
  assign bus.rx_ready       = rx_ready_r;
  assign bus.tx_valid       = tx_valid_r;
  assign bus.tx_data        = tx_data_r;
  assign bus.halt           = halt_r;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
module tb_mem_io_responder;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   vecs = 0;
  int   errs = 0;
  int   cyc  = 0;
  int   c1;
  int   c2;
  bit   seen;

  mem_io_responder_if bus ();

  mem_io_responder #(
    .ADDR_WIDTH    (17),
    .FIFO_DEPTH    (8),
    .FULL_HEADROOM (2),
    .TX_INTERVAL   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0x30001 is an unmapped IO read: returns 0, no side effects.
  task automatic idle();
    bus.mem_a   = 32'h0003_0001;
    bus.mem_wr  = 1'b0;
    bus.mem_din = 8'h00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    bus.mem_a   = a;
    bus.mem_wr  = 1'b1;
    bus.mem_din = d;
    tick();
    idle();
  endtask

  task automatic rd(input logic [31:0] a);
    bus.mem_a  = a;
    bus.mem_wr = 1'b0;
    tick();
    idle();
  endtask

  task automatic wait_tx(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (bus.tx_valid === 1'b1) found = 1'b1;
      else tick();
    end
  endtask

  initial begin
    idle();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.tx_ready = 1'b0;
    rdy = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_mem_dout", bus.mem_dout, 8'h00);
    chk("rst_io_full", bus.io_buffer_full, 1'b0);
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_halt", bus.halt, 1'b0);
    chk("rst_rx_ready", bus.rx_ready, 1'b1);

    // RAM write then single read, exactly one cycle of latency
    wr(32'h0000_0010, 8'hA5);
    chk("ram_wr_no_dout", bus.mem_dout, 8'h00);
    bus.mem_a = 32'h0000_0010;
    tick();
    chk("ram_rd_a5", bus.mem_dout, 8'hA5);
    idle();

    // Back-to-back streaming reads
    wr(32'h0000_0100, 8'h11);
    wr(32'h0000_0101, 8'h22);
    wr(32'h0000_0102, 8'h33);
    wr(32'h0000_0103, 8'h44);
    bus.mem_a = 32'h0000_0100; tick(); chk("stream_0", bus.mem_dout, 8'h11);
    bus.mem_a = 32'h0000_0101; tick(); chk("stream_1", bus.mem_dout, 8'h22);
    bus.mem_a = 32'h0000_0102; tick(); chk("stream_2", bus.mem_dout, 8'h33);
    bus.mem_a = 32'h0000_0103; tick(); chk("stream_3", bus.mem_dout, 8'h44);
    idle();
    tick();
    chk("unmapped_rd_zero", bus.mem_dout, 8'h00);

    // TX flow with pacing
    bus.tx_ready = 1'b1;
    wr(32'h0003_0000, 8'h48);
    wr(32'h0003_0000, 8'h69);
    wait_tx(20, seen);
    chk("tx1_seen", seen, 1'b1);
    chk("tx1_data", bus.tx_data, 8'h48);
    c1 = cyc;
    tick();
    chk("tx_pulse_1cycle", bus.tx_valid, 1'b0);
    wait_tx(20, seen);
    chk("tx2_seen", seen, 1'b1);
    chk("tx2_data", bus.tx_data, 8'h69);
    c2 = cyc;
    chk("tx_gap_ge4", (c2 - c1) >= 4, 1'b1);
    tick();

    // Back-pressure and overflow drop
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'h0003_0000, 8'hB0 + 8'(i));
    chk("bp_full_after5", bus.io_buffer_full, 1'b0);
    wr(32'h0003_0000, 8'hB5);
    chk("bp_full_after6", bus.io_buffer_full, 1'b1);
    wr(32'h0003_0000, 8'hB6);
    wr(32'h0003_0000, 8'hB7);
    wr(32'h0003_0000, 8'hB8);
    rd(32'h0003_0004);
    chk("bp_status_full", bus.mem_dout, 8'h02);
    chk("bp_no_tx", bus.tx_valid, 1'b0);
    bus.tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      wait_tx(20, seen);
      chk($sformatf("drain%0d_seen", k), seen, 1'b1);
      chk($sformatf("drain%0d_data", k), bus.tx_data, 8'hAF + 8'(k));
      chk($sformatf("drain%0d_full", k), bus.io_buffer_full, (8 - k) >= 6);
      tick();
    end
    wait_tx(20, seen);
    chk("drain_no_ninth", seen, 1'b0);

    // RX holding register and status
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h7F;
    tick();
    bus.rx_valid = 1'b0;
    chk("rx_ready_low", bus.rx_ready, 1'b0);
    rd(32'h0003_0004);
    chk("rx_status", bus.mem_dout, 8'h01);
    rd(32'h0003_0000);
    chk("rx_data", bus.mem_dout, 8'h7F);
    chk("rx_ready_back", bus.rx_ready, 1'b1);
    rd(32'h0003_0000);
    chk("rx_empty_rd", bus.mem_dout, 8'h00);

    // Halt, gated by rdy
    rdy = 1'b0;
    bus.mem_a  = 32'h0003_0004;
    bus.mem_wr = 1'b1;
    tick();
    chk("halt_rdy0", bus.halt, 1'b0);
    rdy = 1'b1;
    tick();
    chk("halt_set", bus.halt, 1'b1);
    idle();
    tick();
    chk("halt_sticky", bus.halt, 1'b1);

    // Reset in the middle of a drain
    bus.tx_ready = 1'b0;
    wr(32'h0003_0000, 8'hC0);
    wr(32'h0003_0000, 8'hC1);
    wr(32'h0003_0000, 8'hC2);
    bus.tx_ready = 1'b1;
    wait_tx(20, seen);
    chk("mid_seen", seen, 1'b1);
    chk("mid_data", bus.tx_data, 8'hC0);
    rst = 1'b1;
    tick();
    chk("mid_rst_tx_valid", bus.tx_valid, 1'b0);
    chk("mid_rst_tx_data", bus.tx_data, 8'h00);
    chk("mid_rst_halt", bus.halt, 1'b0);
    chk("mid_rst_io_full", bus.io_buffer_full, 1'b0);
    chk("mid_rst_rx_ready", bus.rx_ready, 1'b1);
    chk("mid_rst_mem_dout", bus.mem_dout, 8'h00);
    rst = 1'b0;
    wait_tx(20, seen);
    chk("mid_fifo_empty", seen, 1'b0);
    rd(32'h0003_0004);
    chk("mid_status", bus.mem_dout, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
